vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Param H_ACTIVE, 640, visible pixels per line.
REQ-002 Params H_FP/H_SYNC/H_BP, 16/96/48, horizontal porch/sync widths in pixels.
REQ-003 Param V_ACTIVE, 480, visible lines per frame.
REQ-004 Params V_FP/V_SYNC/V_BP, 10/2/33, vertical porch/sync widths in lines.
REQ-005 Params HS_POL/VS_POL, 0/0, sync active level.
REQ-006 Param CLK_DIV, 4, clk cycles per pixel; legal 1..16.
REQ-007 Param PIPE_DLY, 0, extra pixel-period delay on timing outputs; legal 0..7.
REQ-008 Param FC_W, 8, frame counter width.
REQ-009 clk  in  1  system clock; all logic on rising edge.
REQ-010 rst  in  1  reset; synchronous, active-low.
REQ-011 en  in  1  run enable; 0 freezes all state and outputs.
REQ-012 pix_en  out  1  one-clk strobe per pixel period.
REQ-013 h_cnt/v_cnt  out  clog2(H_TOTAL)/clog2(V_TOTAL)  lookahead pixel/line counters.
REQ-014 hsync/vsync  out  1  sync outputs at HS_POL/VS_POL.
REQ-015 valid  out  1  active-video flag.
REQ-016 line_start/frame_start  out  1  strobes marking output pixel h=0 / h=0,v=0.
REQ-017 frame_cnt  out  FC_W  completed-frame count.

Function
REQ-018 H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
REQ-019 Divider counts 0..CLK_DIV-1 when en=1; pix_en=en && div==CLK_DIV-1; CLK_DIV=1 gives pix_en=en.
REQ-020 On pix_en h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments; v_cnt wraps at V_TOTAL-1.
REQ-021 frame_cnt increments, modulo 2^FC_W, on the pix_en where (h,v) wraps from (H_TOTAL-1,V_TOTAL-1) to (0,0).
REQ-022 Decode: valid_raw=h<H_ACTIVE && v<V_ACTIVE; hs_raw for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vs_raw same form on v; ls_raw=h==0; fs_raw=h==0&&v==0.
REQ-023 Decodes registered on pix_en, then pass PIPE_DLY further stages each advancing on pix_en only.
REQ-024 Timing outputs lag h_cnt/v_cnt by exactly 1+PIPE_DLY pixel periods; a pixel source of that latency addressed by h_cnt/v_cnt is aligned with valid.
REQ-025 hsync=HS_POL when hs stage is set, else ~HS_POL; vsync likewise.
REQ-026 line_start/frame_start/valid hold for the full pixel period (CLK_DIV clks) of their output pixel.
REQ-027 en=0 mid-frame: divider, counters, pipeline, outputs hold; resume exactly where stopped, no pixel lost or duplicated.

Reset
REQ-028 While rst=0 at clk edge: divider, h_cnt, v_cnt, frame_cnt=0; all pipeline stages inactive.
REQ-029 Reset outputs: hsync=~HS_POL, vsync=~VS_POL, valid=0, line_start=0, frame_start=0, pix_en=0.
REQ-030 Reset mid-frame overrides en and pix_en; first pix_en after release occurs CLK_DIV clks later (en=1).

Configuration
REQ-031 Macro VGA_TESTPAT_EN defined: extra output rgb, out, 12, {R4,G4,B4} test pattern.
REQ-032 Pattern: 8 vertical bars, bar=h_cnt/(H_ACTIVE/8), colours white,yellow,cyan,green,magenta,red,blue,black; rgb=0 when valid=0; rgb passes the same 1+PIPE_DLY stages so it is aligned with valid; reset 0.
REQ-033 Macro undefined: rgb port and pattern logic absent; other behaviour unchanged.

Structure
REQ-034 Package vga_pkg holds the 640x480@60 default timing constants, the test-pattern colour table and clog2 width helpers.
REQ-035 Sub-module vga_pipe_delay: parametrised width/depth shift register advancing on an enable, depth 0 = wire; used for the decode pipeline.

Verification
REQ-036 Defaults, en=1, run 2 frames -> 800 pixel periods/line, 525 lines/frame, hsync low 96 periods, vsync low 2 lines, valid 640x480 per frame.
REQ-037 CLK_DIV=4 -> pix_en every 4th clk; first pix_en at clk 4 after rst release; each valid edge lands on a pix_en boundary.
REQ-038 PIPE_DLY=3 -> first valid rise 4 pixel periods after h_cnt=0,v_cnt=0; frame_start coincides with it.
REQ-039 en=0 for 100 clks at h=300,v=200 -> all outputs frozen; after en=1 h_cnt continues 300->301, no skip.
REQ-040 rst=0 at h=700,v=500 -> next edge: counts 0, hsync/vsync inactive, valid 0; frame_cnt 0 and increments to 1 after one full frame.
REQ-041 VGA_TESTPAT_EN, defaults -> rgb=FFF for h 0..79, FF0 for 80..159, ..., 000 for 560..639; rgb=0 in blanking.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480@60 default timing, decode bundle, colour-bar table
// and counter width helper.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int TESTPAT_W    = 12;

    typedef struct packed {
        logic valid;
        logic hs;
        logic vs;
        logic ls;
        logic fs;
    } timing_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    function automatic logic [TESTPAT_W-1:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return 12'hFFF;
            3'd1:    return 12'hFF0;
            3'd2:    return 12'h0FF;
            3'd3:    return 12'h0F0;
            3'd4:    return 12'hF0F;
            3'd5:    return 12'hF00;
            3'd6:    return 12'h00F;
            3'd7:    return 12'h000;
            default: return 12'h000;
        endcase
    endfunction

endpackage

// File: rtl/vga_pipe_delay.sv
// Enable-advanced shift register of WIDTH bits and DEPTH stages; DEPTH 0 is a wire.
module vga_pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_r [DEPTH];

            // Shift one stage per advance; reset clears every stage
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_r[i] <= '0;
                    end
                end else if (adv) begin
                    stage_r[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end
            end

            assign dout = stage_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with lookahead counters and pipelined timing outputs.
// Define VGA_TESTPAT_EN to add the 12-bit colour-bar output rgb.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = 4,
    parameter int PIPE_DLY = 0,
    parameter int FC_W     = 8,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = cnt_w(H_TOTAL),
    localparam int VW      = cnt_w(V_TOTAL)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    output logic            pix_en,
    output logic [HW-1:0]   h_cnt,
    output logic [VW-1:0]   v_cnt,
    output logic            hsync,
    output logic            vsync,
    output logic            valid,
    output logic            line_start,
    output logic            frame_start,
    output logic [FC_W-1:0] frame_cnt
`ifdef VGA_TESTPAT_EN
    ,
    output logic [TESTPAT_W-1:0] rgb
`endif
);

    localparam int DW = cnt_w(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
`ifdef VGA_TESTPAT_EN
    localparam int PW = $bits(timing_t) + TESTPAT_W;
`else
    localparam int PW = $bits(timing_t);
`endif

    logic [DW-1:0]   div_r;
    logic [HW-1:0]   h_r;
    logic [VW-1:0]   v_r;
    logic [FC_W-1:0] fc_r;
    logic            pix_en_s;
    timing_t         dec_s;
    timing_t         tim_s;
    logic [PW-1:0]   pipe_in_s;
    logic [PW-1:0]   pipe_out_s;

    // Reset gates the strobe so nothing advances on the releasing edge
    assign pix_en_s = rst && en && (div_r == DIV_LAST);

    // Clock divider producing one pixel period every CLK_DIV enabled clocks
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_r <= '0;
        end else if (en) begin
            if (div_r == DIV_LAST) begin
                div_r <= '0;
            end else begin
                div_r <= div_r + DW'(1);
            end
        end
    end

    // Raster position and completed-frame count, one step per pixel period
    always_ff @(posedge clk) begin
        if (!rst) begin
            h_r  <= '0;
            v_r  <= '0;
            fc_r <= '0;
        end else if (pix_en_s) begin
            if (h_r == H_LAST) begin
                h_r <= '0;
                if (v_r == V_LAST) begin
                    v_r  <= '0;
                    fc_r <= fc_r + FC_W'(1);
                end else begin
                    v_r <= v_r + VW'(1);
                end
            end else begin
                h_r <= h_r + HW'(1);
            end
        end
    end

    // Timing decode of the lookahead position
    always_comb begin
        dec_s       = '0;
        dec_s.valid = (h_r < HW'(H_ACTIVE)) && (v_r < VW'(V_ACTIVE));
        dec_s.hs    = (h_r >= HW'(H_ACTIVE + H_FP)) && (h_r < HW'(H_ACTIVE + H_FP + H_SYNC));
        dec_s.vs    = (v_r >= VW'(V_ACTIVE + V_FP)) && (v_r < VW'(V_ACTIVE + V_FP + V_SYNC));
        dec_s.ls    = (h_r == '0);
        dec_s.fs    = (h_r == '0) && (v_r == '0);
    end

`ifdef VGA_TESTPAT_EN
    logic [2:0]           bar_s;
    logic [TESTPAT_W-1:0] pat_s;

    // Colour bar selected by horizontal position, black outside active video
    always_comb begin
        bar_s = 3'(h_r / HW'(H_ACTIVE / 8));
        if (dec_s.valid) begin
            pat_s = bar_colour(bar_s);
        end else begin
            pat_s = '0;
        end
    end

    assign pipe_in_s = {dec_s, pat_s};
    assign tim_s     = pipe_out_s[PW-1:TESTPAT_W];
    assign rgb       = pipe_out_s[TESTPAT_W-1:0];
`else
    assign pipe_in_s = dec_s;
    assign tim_s     = pipe_out_s;
`endif

    // One registering stage plus PIPE_DLY alignment stages, all pixel-paced
    vga_pipe_delay #(
        .WIDTH (PW),
        .DEPTH (1 + PIPE_DLY)
    ) u_pipe (
        .clk  (clk),
        .rst  (rst),
        .adv  (pix_en_s),
        .din  (pipe_in_s),
        .dout (pipe_out_s)
    );

    assign pix_en      = pix_en_s;
    assign h_cnt       = h_r;
    assign v_cnt       = v_r;
    assign frame_cnt   = fc_r;
    assign valid       = tim_s.valid;
    assign line_start  = tim_s.ls;
    assign frame_start = tim_s.fs;
    assign hsync       = tim_s.hs ? HS_POL : ~HS_POL;
    assign vsync       = tim_s.vs ? VS_POL : ~VS_POL;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a reduced raster, compared each cycle
// against a pixel-count model, with randomized enable gaps and resets.
module tb_vga_timing_gen;

    localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
    localparam int VA = 8,  VFP = 1, VSY = 2, VBP = 2;
    localparam int HT = HA + HFP + HSY + HBP;   // 24
    localparam int VT = VA + VFP + VSY + VBP;   // 13
    localparam int CD = 4;
    localparam int PD = 3;
    localparam int FC = 3;
    localparam bit HSP = 1'b0;
    localparam bit VSP = 1'b1;
    localparam int FRAME_CLKS = HT * VT * CD;   // 1248
    localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                         12'hF0F, 12'hF00, 12'h00F, 12'h000};

    typedef struct packed {
        logic        pix_en;
        logic [4:0]  h;
        logic [3:0]  v;
        logic [2:0]  fc;
        logic        hsync;
        logic        vsync;
        logic        valid;
        logic        ls;
        logic        fs;
        logic [11:0] rgb;
    } exp_t;

    logic clk, rst, en;
    logic pix_en, hsync, vsync, valid, line_start, frame_start;
    logic [4:0] h_cnt;
    logic [3:0] v_cnt;
    logic [2:0] frame_cnt;
`ifdef VGA_TESTPAT_EN
    logic [11:0] rgb;
`endif

    int     checks = 0;
    int     errors = 0;
    bit     chk_on = 1'b0;
    longint e_m = 0;
    exp_t   exp_s;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(HSP), .VS_POL(VSP), .CLK_DIV(CD), .PIPE_DLY(PD), .FC_W(FC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pix_en      (pix_en),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .hsync       (hsync),
        .vsync       (vsync),
        .valid       (valid),
        .line_start  (line_start),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
`ifdef VGA_TESTPAT_EN
        ,
        .rgb         (rgb)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: everything follows from e = enabled clocks since reset.
    function automatic exp_t model(input longint e, input logic r, input logic en_i);
        exp_t   x;
        longint n, q, hq, vq;
        x        = '0;
        n        = e / CD;
        x.pix_en = r && en_i && ((e % CD) == CD - 1);
        x.h      = 5'(n % HT);
        x.v      = 4'((n / HT) % VT);
        x.fc     = 3'((n / (HT * VT)) % (1 << FC));
        x.hsync  = ~HSP;
        x.vsync  = ~VSP;
        q        = n - (1 + PD);
        if (q >= 0) begin
            hq      = q % HT;
            vq      = (q / HT) % VT;
            x.valid = (hq < HA) && (vq < VA);
            x.hsync = (hq >= HA + HFP && hq < HA + HFP + HSY) ? HSP : ~HSP;
            x.vsync = (vq >= VA + VFP && vq < VA + VFP + VSY) ? VSP : ~VSP;
            x.ls    = (hq == 0);
            x.fs    = (hq == 0) && (vq == 0);
            x.rgb   = x.valid ? BARS[int'(hq / (HA / 8))] : 12'h000;
        end
        return x;
    endfunction

    always @(posedge clk) begin
        if (!rst)    e_m <= 0;
        else if (en) e_m <= e_m + 1;
    end

    assign exp_s = model(e_m, rst, en);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name, input int budget);
        checks++;
        errors++;
        $display("FAIL %s timeout after %0d cycles at %0t", name, budget, $time);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("pix_en",      pix_en,      exp_s.pix_en);
            check("h_cnt",       h_cnt,       exp_s.h);
            check("v_cnt",       v_cnt,       exp_s.v);
            check("frame_cnt",   frame_cnt,   exp_s.fc);
            check("hsync",       hsync,       exp_s.hsync);
            check("vsync",       vsync,       exp_s.vsync);
            check("valid",       valid,       exp_s.valid);
            check("line_start",  line_start,  exp_s.ls);
            check("frame_start", frame_start, exp_s.fs);
`ifdef VGA_TESTPAT_EN
            check("rgb",         rgb,         exp_s.rgb);
`endif
        end
    end

    function automatic logic sel(input int which);
        case (which)
            0:       return valid;
            1:       return hsync;
            2:       return line_start;
            default: return frame_start;
        endcase
    endfunction

    // Step whole clocks until the selected output equals level; cyc = clocks taken.
    task automatic wait_for(input int which, input logic level, input int budget,
                            input string name, output int cyc);
        cyc = 0;
        while (sel(which) !== level && cyc < budget) begin
            @(posedge clk); #2;
            cyc++;
        end
        if (cyc >= budget) timeout(name, budget);
    endtask

    task automatic wait_hv(input int h, input int v, input int budget, input string name);
        int c;
        c = 0;
        while (!(h_cnt == h && v_cnt == v) && c < budget) begin
            @(posedge clk); #2;
            c++;
        end
        if (c >= budget) timeout(name, budget);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int c1, c2, hold, cyc;
        rst = 1'b0;
        en  = 1'b0;
        @(posedge clk); #2;
        chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_h",     h_cnt,     32'd0);
        check("rst_v",     v_cnt,     32'd0);
        check("rst_fc",    frame_cnt, 32'd0);
        check("rst_hsync", hsync,     32'd1);
        check("rst_vsync", vsync,     32'd0);
        check("rst_valid", valid,     32'd0);

        // First pixel advance lands on the 4th clock after release
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) @(posedge clk);
        #2 check("pre_first_pix_h", h_cnt, 32'd0);
        @(posedge clk);
        #2 check("first_pix_h", h_cnt, 32'd1);

        // Output pipeline is 1+3 pixel periods behind the counters
        wait_for(0, 1'b1, 200, "first_valid", cyc);
        check("first_valid_h",  h_cnt,       32'd4);
        check("first_valid_v",  v_cnt,       32'd0);
        check("first_valid_fs", frame_start, 32'd1);

        wait_for(1, 1'b0, 200, "hsync_fall", cyc);
        wait_for(1, 1'b1, 200, "hsync_rise", cyc);
        check("hsync_width_clks", cyc, HSY * CD);

        wait_for(2, 1'b1, 200, "ls_a", cyc);
        wait_for(2, 1'b0, 200, "ls_b", c1);
        wait_for(2, 1'b1, 200, "ls_c", c2);
        check("ls_hold_clks", c1, CD);
        check("line_clks", c1 + c2, HT * CD);

        wait_for(3, 1'b1, 2 * FRAME_CLKS, "fs_a", cyc);
        wait_for(3, 1'b0, 2 * FRAME_CLKS, "fs_b", c1);
        wait_for(3, 1'b1, 2 * FRAME_CLKS, "fs_c", c2);
        check("frame_clks", c1 + c2, FRAME_CLKS);

        // Freeze for 100 clocks mid-frame, then resume without skipping
        wait_hv(10, 5, 2 * FRAME_CLKS, "reach_10_5");
        en = 1'b0;
        repeat (100) @(posedge clk);
        #2 check("frozen_h", h_cnt, 32'd10);
        en  = 1'b1;
        cyc = 0;
        while (h_cnt == 5'd10 && cyc < 20) begin
            @(posedge clk); #2;
            cyc++;
        end
        check("resume_h",    h_cnt, 32'd11);
        check("resume_clks", cyc,   CD);

        // Random enable gaps with one short reset pulse
        hold = 0;
        for (int i = 0; i < 6000; i++) begin
            if (i == 3000) begin
                rst = 1'b0;
                repeat ($urandom_range(1, 5)) @(posedge clk);
                #2 rst = 1'b1;
            end
            if (hold == 0) begin
                en   = ($urandom_range(0, 3) != 0);
                hold = $urandom_range(1, 20);
            end
            hold--;
            @(posedge clk); #2;
        end

        // Reset in vertical blanking, then one full frame to the first count
        en = 1'b1;
        wait_hv(20, 11, 2 * FRAME_CLKS, "reach_20_11");
        rst = 1'b0;
        @(posedge clk); #2;
        check("mid_rst_h",     h_cnt,     32'd0);
        check("mid_rst_v",     v_cnt,     32'd0);
        check("mid_rst_hsync", hsync,     32'd1);
        check("mid_rst_vsync", vsync,     32'd0);
        check("mid_rst_valid", valid,     32'd0);
        check("mid_rst_fc",    frame_cnt, 32'd0);
        rst = 1'b1;
        cyc = 0;
        while (frame_cnt == 3'd0 && cyc < 2 * FRAME_CLKS) begin
            @(posedge clk); #2;
            cyc++;
        end
        check("fc_first_clks", cyc,       FRAME_CLKS);
        check("fc_first",      frame_cnt, 32'd1);

        // Frame counter wraps 7 -> 0
        cyc = 0;
        while (frame_cnt != 3'd7 && cyc < 8 * FRAME_CLKS) begin
            @(posedge clk); #2;
            cyc++;
        end
        if (cyc >= 8 * FRAME_CLKS) timeout("fc_reach_7", 8 * FRAME_CLKS);
        cyc = 0;
        while (frame_cnt == 3'd7 && cyc < 2 * FRAME_CLKS) begin
            @(posedge clk); #2;
            cyc++;
        end
        check("fc_wrap_clks", cyc,       FRAME_CLKS);
        check("fc_wrap",      frame_cnt, 32'd0);

        repeat (10) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
